piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in, serial-out shift-register transmitter. It is the sending end of the single-bit serial stream that the team's shift-register delay and receive paths consume.
- Accepts one DATA_WIDTH-bit word per valid/ready handshake and shifts it out one bit per clock on odata.
- Frame markers ofirst and olast let a downstream shift-register receiver align words.
- Back-to-back words stream with no idle gap.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit DATA_WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0, value driven on odata when no word is being sent.

Ports:
- iclock  input  1  system clock; all logic on the rising edge.
- ireset  input  1  synchronous, active-high reset.
- idata  input  DATA_WIDTH  parallel word to send; sampled only on an accept edge.
- ivalid  input  1  idata holds a word to send.
- oready  output  1  transmitter can accept a word this cycle.
- odata  output  1  serial bit out (registered).
- ofirst  output  1  high while odata carries bit 1 of a word (registered).
- olast  output  1  high while odata carries bit DATA_WIDTH of a word (registered).
- obusy  output  1  high while any bit of a word is on odata (registered).

Behaviour:
- Clock and reset: one clock, iclock. Reset ireset is synchronous and active-high.
- Reset values: state IDLE, shift register 0, bit counter 0, odata=IDLE_LEVEL, ofirst=0, olast=0, obusy=0.
- During reset: oready is forced to 0 while ireset=1, and ivalid is ignored.
- States: IDLE and SHIFT. Internally there is a DATA_WIDTH-bit shift register and a bit counter of clog2(DATA_WIDTH) bits.
- oready (combinational from registered state): 1 when ireset=0 and either (a) state=IDLE, or (b) state=SHIFT with the counter at DATA_WIDTH-1, i.e. the last bit is on odata.
- Accept: a word is accepted at a rising edge where ivalid=1 and oready=1.
- On accept, at that same edge:
  - load the shift register from idata;
  - odata <= first bit (idata[DATA_WIDTH-1] if MSB_FIRST, else idata[0]);
  - ofirst <= 1, obusy <= 1, counter <= 0, state <= SHIFT.
- Latency: the first bit is visible on odata in the cycle right after the accept edge.
- Each subsequent edge in SHIFT: counter increments and odata <= next bit in transmit order, so each bit is held exactly one cycle.
- ofirst is 1 only while counter=0. olast is 1 only while counter=DATA_WIDTH-1.
- Last-bit edge (counter=DATA_WIDTH-1):
  - if accept occurs: the new word's first bit follows with zero gap (ofirst=1 next cycle, obusy stays 1);
  - otherwise: state <= IDLE, odata <= IDLE_LEVEL, obusy <= 0, ofirst <= 0, olast <= 0.
- ivalid while busy: ivalid asserted during SHIFT when counter != DATA_WIDTH-1 is not accepted. The source must hold ivalid/idata until oready=1; changing idata while not accepted has no effect.
- idata stability: idata may change freely after the accept edge; the transmitted word is the value captured at accept.
- Reset mid-word: the next edge with ireset=1 aborts the word. odata=IDLE_LEVEL and all markers are 0 from the following cycle. No partial-word resume.
- Marker consistency: olast and ofirst never assert together, since DATA_WIDTH >= 2.
- Throughput: continuous ivalid gives exactly one word every DATA_WIDTH cycles.

Test Plan:
1. Single word: DATA_WIDTH=8, MSB_FIRST=1, reset, then idata=0xA5 with ivalid for one accept edge -> odata=1,0,1,0,0,1,0,1 on the 8 following cycles; ofirst on cycle 1, olast on cycle 8; then odata=0 and oready=1.
2. Back-to-back: hold ivalid, send 0xA5 then 0x3C -> 16 contiguous bits 10100101 00111100; obusy stays high; ofirst at cycles 1 and 9; olast at cycles 8 and 16.
3. LSB-first: MSB_FIRST=0, IDLE_LEVEL=1, idata=0x01 -> odata=1,0,0,0,0,0,0,0; odata=1 when idle before and after.
4. Busy hold-off: accept 0xFF, then assert ivalid with idata=0x00 from cycle 2 -> oready=0 on cycles 1-7; 0x00 is accepted only at the last-bit edge; output is 8 ones then 8 zeros.
5. Reset mid-word: accept 0xF0, assert ireset for one cycle at bit 4 -> odata=IDLE_LEVEL with ofirst, olast and obusy=0 from the next cycle; a new 0x81 afterwards transmits as 1,0,0,0,0,0,0,1.
6. Reset-held handshake: ireset=1 with ivalid=1 for 3 cycles -> oready=0 and odata stays IDLE_LEVEL; oready=1 in the first cycle after ireset drops.

Source files
------------

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter with valid/ready input and first/last frame markers.
module piso_shift_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  iclock,
  input  logic                  ireset,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  oready,
  output logic                  odata,
  output logic                  ofirst,
  output logic                  olast,
  output logic                  obusy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DATA_WIDTH - 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] sr, sr_rot;
  logic [CW-1:0] cnt;
  logic last_bit, accept, nxt;
  always_comb begin
    last_bit = state == SHIFT && cnt == LAST;
    oready   = !ireset && (state == IDLE || last_bit);
    accept   = ivalid && oready;
    state_n  = accept ? SHIFT : last_bit ? IDLE : state;
    // rotate so the bit after the one on odata is always at a fixed position
    sr_rot   = MSB_FIRST ? {sr[DATA_WIDTH-2:0], sr[DATA_WIDTH-1]} : {sr[0], sr[DATA_WIDTH-1:1]};
    nxt      = MSB_FIRST ? sr[DATA_WIDTH-2] : sr[1];
  end
  always_ff @(posedge iclock)
    state <= ireset ? IDLE : state_n;
  always_ff @(posedge iclock) begin
    if (ireset) begin
      sr     <= '0;
      cnt    <= '0;
      odata  <= IDLE_LEVEL;
      ofirst <= 1'b0;
      olast  <= 1'b0;
      obusy  <= 1'b0;
    end else if (accept) begin
      sr     <= idata;
      cnt    <= '0;
      odata  <= MSB_FIRST ? idata[DATA_WIDTH-1] : idata[0];
      ofirst <= 1'b1;
      olast  <= 1'b0;
      obusy  <= 1'b1;
    end else if (last_bit) begin
      odata  <= IDLE_LEVEL;
      ofirst <= 1'b0;
      olast  <= 1'b0;
      obusy  <= 1'b0;
    end else if (state == SHIFT) begin
      sr     <= sr_rot;
      cnt    <= cnt + CW'(1);
      odata  <= nxt;
      ofirst <= 1'b0;
      olast  <= cnt == PRE_LAST;
    end
  end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: scoreboard bench for piso_shift_tx, MSB-first/idle-0 and LSB-first/idle-1 instances.
module tb_piso_shift_tx;
  logic clk = 1'b0;
  logic ireset = 1'b0;
  logic [7:0] idata = '0;
  logic ivalid = 1'b0, ivalid2 = 1'b0;
  logic oready, odata, ofirst, olast, obusy;
  logic oready2, odata2, ofirst2, olast2, obusy2;
  int checks = 0, errors = 0;
  typedef struct packed { logic d; logic f; logic l; } exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .iclock(clk), .ireset(ireset), .idata(idata), .ivalid(ivalid), .oready(oready),
    .odata(odata), .ofirst(ofirst), .olast(olast), .obusy(obusy));

  piso_shift_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut2 (
    .iclock(clk), .ireset(ireset), .idata(idata), .ivalid(ivalid2), .oready(oready2),
    .odata(odata2), .ofirst(ofirst2), .olast(olast2), .obusy(obusy2));

  function automatic void push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++)
      q.push_back('{d: w[msb ? 7 - i : i], f: i == 0, l: i == 7});
  endfunction

  task automatic test_reset;
    @(posedge clk); #1 ireset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({oready, odata, ofirst, olast, obusy, odata2} !== 6'b000001) begin
      errors++; $display("FAIL reset: got %b want 000001", {oready, odata, ofirst, olast, obusy, odata2});
    end
    @(posedge clk); #1 ireset = 1'b0;
    @(negedge clk);
    checks++;
    if ({oready, oready2} !== 2'b11) begin
      errors++; $display("FAIL reset_release ready: got %b want 11", {oready, oready2});
    end
  endtask

  task automatic test_single;
    @(posedge clk); #1 ivalid = 1'b1; idata = 8'hA5; push_word(8'hA5, 1'b1);
    @(posedge clk); #1 ivalid = 1'b0; idata = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata, ofirst, olast, obusy} !== {e.d, e.f, e.l, 1'b1}) begin
        errors++; $display("FAIL single bit%0d: got %b want %b", c, {odata, ofirst, olast, obusy}, {e.d, e.f, e.l, 1'b1});
      end
    end
    @(negedge clk);
    checks++;
    if ({odata, obusy, oready} !== 3'b001) begin
      errors++; $display("FAIL single idle: got %b want 001", {odata, obusy, oready});
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1 ivalid = 1'b1; idata = 8'hA5; push_word(8'hA5, 1'b1);
    @(posedge clk); #1 idata = 8'h3C; push_word(8'h3C, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata, ofirst, olast, obusy} !== {e.d, e.f, e.l, 1'b1}) begin
        errors++; $display("FAIL b2b bit%0d: got %b want %b", c, {odata, ofirst, olast, obusy}, {e.d, e.f, e.l, 1'b1});
      end
      if (c == 8) begin
        @(posedge clk); #1 ivalid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({odata, obusy, oready} !== 3'b001) begin
      errors++; $display("FAIL b2b idle: got %b want 001", {odata, obusy, oready});
    end
  endtask

  task automatic test_lsb_first;
    @(negedge clk);
    checks++;
    if ({odata2, obusy2} !== 2'b10) begin
      errors++; $display("FAIL lsb idle_before: got %b want 10", {odata2, obusy2});
    end
    @(posedge clk); #1 ivalid2 = 1'b1; idata = 8'h01; push_word(8'h01, 1'b0);
    @(posedge clk); #1 ivalid2 = 1'b0; idata = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata2, ofirst2, olast2, obusy2} !== {e.d, e.f, e.l, 1'b1}) begin
        errors++; $display("FAIL lsb bit%0d: got %b want %b", c, {odata2, ofirst2, olast2, obusy2}, {e.d, e.f, e.l, 1'b1});
      end
    end
    @(negedge clk);
    checks++;
    if ({odata2, obusy2, oready2} !== 3'b101) begin
      errors++; $display("FAIL lsb idle_after: got %b want 101", {odata2, obusy2, oready2});
    end
  endtask

  task automatic test_busy_holdoff;
    @(posedge clk); #1 ivalid = 1'b1; idata = 8'hFF; push_word(8'hFF, 1'b1);
    @(posedge clk); #1 ivalid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata, ofirst, olast, obusy, oready} !== {e.d, e.f, e.l, 1'b1, c == 8 || c == 16}) begin
        errors++; $display("FAIL holdoff bit%0d: got %b want %b", c, {odata, ofirst, olast, obusy, oready}, {e.d, e.f, e.l, 1'b1, c == 8 || c == 16});
      end
      if (c == 1) begin
        @(posedge clk); #1 ivalid = 1'b1; idata = 8'h00; push_word(8'h00, 1'b1);
      end
      if (c == 8) begin
        @(posedge clk); #1 ivalid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({obusy, oready} !== 2'b01) begin
      errors++; $display("FAIL holdoff idle: got %b want 01", {obusy, oready});
    end
  endtask

  task automatic test_reset_mid_word;
    @(posedge clk); #1 ivalid = 1'b1; idata = 8'hF0; push_word(8'hF0, 1'b1);
    @(posedge clk); #1 ivalid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata, ofirst, olast, obusy} !== {e.d, e.f, e.l, 1'b1}) begin
        errors++; $display("FAIL midreset bit%0d: got %b want %b", c, {odata, ofirst, olast, obusy}, {e.d, e.f, e.l, 1'b1});
      end
      if (c == 3) begin
        @(posedge clk); #1 ireset = 1'b1;
      end
    end
    q.delete();
    @(posedge clk); #1 ireset = 1'b0;
    @(negedge clk);
    checks++;
    if ({odata, ofirst, olast, obusy, oready} !== 5'b00001) begin
      errors++; $display("FAIL midreset abort: got %b want 00001", {odata, ofirst, olast, obusy, oready});
    end
    @(posedge clk); #1 ivalid = 1'b1; idata = 8'h81; push_word(8'h81, 1'b1);
    @(posedge clk); #1 ivalid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({odata, ofirst, olast, obusy} !== {e.d, e.f, e.l, 1'b1}) begin
        errors++; $display("FAIL after_reset bit%0d: got %b want %b", c, {odata, ofirst, olast, obusy}, {e.d, e.f, e.l, 1'b1});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_held_handshake;
    @(posedge clk); #1 ireset = 1'b1; ivalid = 1'b1; ivalid2 = 1'b1; idata = 8'h55;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({oready, odata, obusy, oready2, odata2, obusy2} !== 6'b000010) begin
        errors++; $display("FAIL held_reset cyc%0d: got %b want 000010", c, {oready, odata, obusy, oready2, odata2, obusy2});
      end
      @(posedge clk);
    end
    #1 ireset = 1'b0;
    @(negedge clk);
    checks++;
    if ({oready, oready2, obusy, odata} !== 4'b1100) begin
      errors++; $display("FAIL held_reset release: got %b want 1100", {oready, oready2, obusy, odata});
    end
    ivalid = 1'b0; ivalid2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({obusy, odata, obusy2, odata2} !== 4'b0001) begin
      errors++; $display("FAIL held_reset idle: got %b want 0001", {obusy, odata, obusy2, odata2});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_lsb_first;
    test_busy_holdoff;
    test_reset_mid_word;
    test_reset_held_handshake;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
